// File: rtl/alu_shift_mul.sv
// ============================================================================
// Module   : alu_shift_mul
// Purpose  : Iterative unsigned shift-add multiplier, one multiplier bit per
//            clock, full 2W-bit product with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_mul #(
  parameter int W = 32
) (
  input  logic           c,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic [2*W:0]   sum;
  logic [2*W-1:0] acc_shifted;

  // Adding mcand into the upper half keeps the carry in bit 2W; the shift
  // then folds that carry back into the accumulator's top bit.
  always_comb begin
    sum         = {1'b0, acc_q} +
                  (mplier_q[0] ? {1'b0, mcand_q, {W{1'b0}}} : {(2*W+1){1'b0}});
    acc_shifted = (2*W)'(sum >> 1);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end else if (state_q == S_DONE) begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_shifted;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          p_d     = acc_shifted;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_mul.sv
// ============================================================================
// Module   : tb_alu_shift_mul
// Purpose  : Self-checking bench for alu_shift_mul against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_mul;

  localparam int W = 32;

  logic           c = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [2*W-1:0] last_p;
  bit             saw_done;

  alu_shift_mul #(.W(W)) dut (
    .c     (c),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  // Accept edge is the first tick; returns right after the completion edge.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit keep_start,
                       input int inj_cyc, input logic [31:0] ix, input logic [31:0] iy);
    logic [63:0] exp;
    exp   = ref_mul(x, y);
    start = 1'b1;
    a     = x;
    b     = y;
    tick();
    if (!keep_start) begin
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
    end
    for (int i = 1; i < W; i++) begin
      if (i == inj_cyc) begin
        start = 1'b1;
        a     = ix;
        b     = iy;
      end else if (!keep_start) begin
        start = 1'b0;
      end
      tick();
      chk("busy_run", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      if (i == W - 1) chk("p_hold_run", p, last_p);
    end
    if (!keep_start) start = 1'b0;
    tick();
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("product", p, exp);
    last_p = exp;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    last_p = '0;

    repeat (3) @(posedge c);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_p", p, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_p", p, 64'd0);
    end

    do_op(32'd3, 32'd5, 1'b0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_done", 64'(done), 64'd0);
      chk("post_busy", 64'(busy), 64'd0);
      chk("p_hold_idle", p, 64'h0000_0000_0000_000F);
    end

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'd0);
    chk("max_const", p, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0, 32'd0, 32'd0);
    do_op(32'h8000_0000, 32'h0000_0002, 1'b0, 0, 32'd0, 32'd0);
    chk("msb_const", p, 64'h0000_0001_0000_0000);

    // start during RUN must be ignored, with no second completion.
    do_op(32'd7, 32'd6, 1'b0, 10, 32'd9, 32'd9);
    chk("busy_prot", p, 64'd42);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("no_second_op", 64'(saw_done), 64'd0);

    do_op(32'd2, 32'd3, 1'b1, 0, 32'd0, 32'd0);
    do_op(32'd4, 32'd5, 1'b1, 0, 32'd0, 32'd0);
    chk("b2b_second", p, 64'd20);
    start = 1'b0;
    tick();
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    chk("b2b_idle_done", 64'(done), 64'd0);

    start = 1'b1;
    a     = 32'h1234;
    b     = 32'h1234;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_p", p, 64'd0);
    last_p = '0;
    @(posedge c);
    @(posedge c);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    do_op(32'h1234, 32'h1234, 1'b0, 0, 32'd0, 32'd0);
    chk("after_abort", p, 64'h0000_0000_014B_5A90);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          gap;
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) ra = 32'hFFFF_FFFF;
      if (n % 7 == 3) rb = 32'd1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_done", 64'(done), 64'd0);
      end
      do_op(ra, rb, 1'b0, 0, 32'd0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
